// File: rtl/typer_game_ctrl_if.sv
// Handshake between the game sequencer (master) and the keyboard reader (slave).
interface typer_game_ctrl_if;
  logic start_read;
  logic retry;
  logic key_any;
  logic key_correct;
  logic level_done;
  logic level_timeout;

  modport master (
    output start_read, retry,
    input  key_any, key_correct, level_done, level_timeout
  );

  modport slave (
    input  start_read, retry,
    output key_any, key_correct, level_done, level_timeout
  );
endinterface

// File: rtl/typer_game_ctrl.sv
// Speed-typing game sequencer: levels, score, error budget, lives and inter-level pause.
// Optional high-score register enabled by defining TYPER_HISCORE_EN.
module typer_game_ctrl #(
  parameter int NUM_LEVELS = 8,
  parameter int NUM_LIVES  = 3,
  parameter int GAP_CYCLES = 50000000,
  parameter int BONUS      = 4,
  parameter int MAX_ERR    = 5,
  parameter int SCORE_W    = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_btn,
  typer_game_ctrl_if.master  rd,
  output logic [3:0]         level,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         lives,
  output logic [2:0]         err_cnt,
  output logic [2:0]         state_dbg,
  output logic               game_over,
  output logic               game_won
`ifdef TYPER_HISCORE_EN
  ,
  output logic [SCORE_W-1:0] hiscore
`endif
);

  typedef enum logic [2:0] {
    IDLE = 3'd0, ARM = 3'd1, PLAY = 3'd2, DONE = 3'd3,
    FAIL = 3'd4, GAP = 3'd5, OVER = 3'd6, WIN  = 3'd7
  } state_t;

  localparam int SUM_W = SCORE_W + 8;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [3:0]       LAST_LVL  = 4'(NUM_LEVELS);
  localparam logic [2:0]       LIVES_INI = 3'(NUM_LIVES);
  localparam logic [7:0]       ERR_LIM   = 8'(MAX_ERR);

  state_t             state_q;
  logic [3:0]         level_q;
  logic [SCORE_W-1:0] score_q;
  logic [2:0]         lives_q;
  logic [2:0]         err_q;
  logic [GAP_W-1:0]   gap_q;
  logic               start_read_q;
  logic               retry_q;
  logic               retry_pend_q;
  logic               over_q;
  logic               won_q;
  logic [SUM_W-1:0]   bonus_sum;
  logic [SCORE_W-1:0] bonus_score;
  logic               err_over;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (&s) ? s : s + 1'b1;
  endfunction

  function automatic logic [SCORE_W-1:0] sat_clamp(input logic [SUM_W-1:0] v);
    return (|v[SUM_W-1:SCORE_W]) ? {SCORE_W{1'b1}} : v[SCORE_W-1:0];
  endfunction

  function automatic logic [2:0] sat_inc3(input logic [2:0] e);
    return (&e) ? e : e + 3'd1;
  endfunction

  // Bonus is summed wide so the clamp sees any overflow.
  assign bonus_sum   = SUM_W'(score_q) + SUM_W'(BONUS) * SUM_W'(level_q);
  assign bonus_score = sat_clamp(bonus_sum);
  assign err_over    = {5'd0, err_q} > ERR_LIM;

`ifdef TYPER_HISCORE_EN
  logic [SCORE_W-1:0] hiscore_q;
  assign hiscore = hiscore_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      level_q      <= 4'd1;
      score_q      <= '0;
      lives_q      <= LIVES_INI;
      err_q        <= 3'd0;
      gap_q        <= '0;
      start_read_q <= 1'b0;
      retry_q      <= 1'b0;
      retry_pend_q <= 1'b0;
      over_q       <= 1'b0;
      won_q        <= 1'b0;
`ifdef TYPER_HISCORE_EN
      hiscore_q    <= '0;
`endif
    end else begin
      start_read_q <= 1'b0;
      retry_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_btn) begin
            state_q      <= ARM;
            start_read_q <= 1'b1;
          end
        end
        ARM: begin
          err_q   <= 3'd0;
          state_q <= PLAY;
        end
        PLAY: begin
          if (rd.key_any) begin
            if (rd.key_correct) score_q <= sat_inc(score_q);
            else                err_q   <= sat_inc3(err_q);
          end
          if (rd.level_done)                      state_q <= DONE;
          else if (rd.level_timeout || err_over)  state_q <= FAIL;
        end
        DONE: begin
          score_q      <= bonus_score;
          retry_pend_q <= 1'b0;
          if (level_q == LAST_LVL) begin
            state_q <= WIN;
            won_q   <= 1'b1;
`ifdef TYPER_HISCORE_EN
            if (bonus_score > hiscore_q) hiscore_q <= bonus_score;
`endif
          end else begin
            level_q <= level_q + 4'd1;
            gap_q   <= GAP_LOAD;
            state_q <= GAP;
          end
        end
        FAIL: begin
          lives_q <= lives_q - 3'd1;
          if (lives_q == 3'd1) begin
            state_q <= OVER;
            over_q  <= 1'b1;
`ifdef TYPER_HISCORE_EN
            if (score_q > hiscore_q) hiscore_q <= score_q;
`endif
          end else begin
            retry_pend_q <= 1'b1;
            gap_q        <= GAP_LOAD;
            state_q      <= GAP;
          end
        end
        GAP: begin
          if (gap_q == '0) begin
            state_q      <= ARM;
            start_read_q <= 1'b1;
            retry_q      <= retry_pend_q;
          end else begin
            gap_q <= gap_q - 1'b1;
          end
        end
        OVER, WIN: begin
          if (start_btn) begin
            score_q      <= '0;
            level_q      <= 4'd1;
            lives_q      <= LIVES_INI;
            retry_pend_q <= 1'b0;
            over_q       <= 1'b0;
            won_q        <= 1'b0;
            start_read_q <= 1'b1;
            state_q      <= ARM;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd.start_read = start_read_q;
  assign rd.retry      = retry_q;
  assign level         = level_q;
  assign score         = score_q;
  assign lives         = lives_q;
  assign err_cnt       = err_q;
  assign state_dbg     = state_q;
  assign game_over     = over_q;
  assign game_won      = won_q;

endmodule

// File: tb/tb_typer_game_ctrl.sv
// Directed bench for typer_game_ctrl with a short gap and two levels.
module tb_typer_game_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic       start_btn;
  logic [3:0] level;
  logic [7:0] score;
  logic [2:0] lives, err_cnt, state_dbg;
  logic       game_over, game_won;
`ifdef TYPER_HISCORE_EN
  logic [7:0] hiscore;
`endif
  int total = 0;
  int bad   = 0;

  typer_game_ctrl_if rif ();

  typer_game_ctrl #(
    .NUM_LEVELS(2), .NUM_LIVES(2), .GAP_CYCLES(4),
    .BONUS(4), .MAX_ERR(2), .SCORE_W(8)
  ) dut (
    .clk(clk), .reset(reset), .start_btn(start_btn), .rd(rif),
    .level(level), .score(score), .lives(lives), .err_cnt(err_cnt),
    .state_dbg(state_dbg), .game_over(game_over), .game_won(game_won)
`ifdef TYPER_HISCORE_EN
    , .hiscore(hiscore)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_sr(output int n);
    n = -1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (rif.start_read === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(2); reset = 1'b0;
    total++; if (state_dbg !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
    total++; if ({level, score, lives, err_cnt} !== {4'd1, 8'd0, 3'd2, 3'd0}) begin bad++; $display("FAIL reset_vals got lvl=%0d sc=%0d lv=%0d err=%0d", level, score, lives, err_cnt); end
    total++; if ({rif.start_read, rif.retry, game_over, game_won} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {rif.start_read, rif.retry, game_over, game_won}); end
  endtask

  task automatic test_start();
    start_btn = 1'b1; tick(); start_btn = 1'b0;
    total++; if ({rif.start_read, rif.retry, state_dbg} !== {1'b1, 1'b0, 3'd1}) begin bad++; $display("FAIL start_pulse got sr=%b rt=%b st=%0d exp sr=1 rt=0 st=1", rif.start_read, rif.retry, state_dbg); end
    total++; if ({level, lives, score} !== {4'd1, 3'd2, 8'd0}) begin bad++; $display("FAIL start_vals got lvl=%0d lv=%0d sc=%0d", level, lives, score); end
    tick();
    total++; if ({rif.start_read, state_dbg} !== {1'b0, 3'd2}) begin bad++; $display("FAIL start_play got sr=%b st=%0d exp sr=0 st=2", rif.start_read, state_dbg); end
  endtask

  task automatic test_level_clear();
    int n;
    rif.key_any = 1'b1; rif.key_correct = 1'b1; tick(3);
    rif.key_any = 1'b0; rif.key_correct = 1'b0;
    rif.level_done = 1'b1; tick(); rif.level_done = 1'b0;
    total++; if ({state_dbg, score} !== {3'd3, 8'd3}) begin bad++; $display("FAIL clear_done got st=%0d sc=%0d exp st=3 sc=3", state_dbg, score); end
    tick();
    total++; if ({state_dbg, score, level} !== {3'd5, 8'd7, 4'd2}) begin bad++; $display("FAIL clear_bonus got st=%0d sc=%0d lvl=%0d exp st=5 sc=7 lvl=2", state_dbg, score, level); end
    wait_sr(n);
    total++; if (n !== 4) begin bad++; $display("FAIL gap_latency got=%0d exp=4 (5 after DONE)", n); end
    total++; if ({rif.retry, level} !== {1'b0, 4'd2}) begin bad++; $display("FAIL advance got rt=%b lvl=%0d exp rt=0 lvl=2", rif.retry, level); end
    tick();
  endtask

  task automatic test_timeout_over();
    int n;
    rif.level_timeout = 1'b1; tick(); rif.level_timeout = 1'b0;
    total++; if (state_dbg !== 3'd4) begin bad++; $display("FAIL to_fail got=%0d exp=4", state_dbg); end
    tick();
    total++; if ({state_dbg, lives} !== {3'd5, 3'd1}) begin bad++; $display("FAIL fail_lives got st=%0d lv=%0d exp st=5 lv=1", state_dbg, lives); end
    wait_sr(n);
    total++; if ({n[7:0], rif.retry, level} !== {8'd4, 1'b1, 4'd2}) begin bad++; $display("FAIL retry_arm got n=%0d rt=%b lvl=%0d exp n=4 rt=1 lvl=2", n, rif.retry, level); end
    tick();
    rif.level_timeout = 1'b1; tick(); rif.level_timeout = 1'b0;
    tick();
    total++; if ({state_dbg, game_over, lives} !== {3'd6, 1'b1, 3'd0}) begin bad++; $display("FAIL over got st=%0d go=%b lv=%0d exp st=6 go=1 lv=0", state_dbg, game_over, lives); end
    rif.key_any = 1'b1; rif.key_correct = 1'b1; rif.level_done = 1'b1; tick(3);
    rif.key_any = 1'b0; rif.key_correct = 1'b0; rif.level_done = 1'b0;
    total++; if ({state_dbg, score, rif.start_read} !== {3'd6, 8'd7, 1'b0}) begin bad++; $display("FAIL over_hold got st=%0d sc=%0d sr=%b exp st=6 sc=7 sr=0", state_dbg, score, rif.start_read); end
  endtask

  task automatic test_errors();
    int n;
    start_btn = 1'b1; tick(); start_btn = 1'b0;
    total++; if ({rif.start_read, rif.retry, score, level, lives, game_over} !== {1'b1, 1'b0, 8'd0, 4'd1, 3'd2, 1'b0}) begin bad++; $display("FAIL restart_over got sr=%b rt=%b sc=%0d lvl=%0d lv=%0d go=%b", rif.start_read, rif.retry, score, level, lives, game_over); end
    tick();
    rif.key_any = 1'b1; rif.key_correct = 1'b0; tick(3); rif.key_any = 1'b0;
    total++; if ({err_cnt, state_dbg, score} !== {3'd3, 3'd2, 8'd0}) begin bad++; $display("FAIL err_count got err=%0d st=%0d sc=%0d exp err=3 st=2 sc=0", err_cnt, state_dbg, score); end
    tick();
    total++; if (state_dbg !== 3'd4) begin bad++; $display("FAIL err_fail got=%0d exp=4", state_dbg); end
    tick();
    wait_sr(n);
    total++; if ({n[7:0], rif.retry, level, lives} !== {8'd4, 1'b1, 4'd1, 3'd1}) begin bad++; $display("FAIL err_retry got n=%0d rt=%b lvl=%0d lv=%0d", n, rif.retry, level, lives); end
    tick();
    total++; if (err_cnt !== 3'd0) begin bad++; $display("FAIL err_clear got=%0d exp=0", err_cnt); end
  endtask

  task automatic test_done_wins();
    int n;
    rif.level_done = 1'b1; rif.level_timeout = 1'b1; rif.key_any = 1'b1; rif.key_correct = 1'b1;
    tick();
    rif.level_done = 1'b0; rif.level_timeout = 1'b0; rif.key_any = 1'b0; rif.key_correct = 1'b0;
    total++; if ({state_dbg, lives, score} !== {3'd3, 3'd1, 8'd1}) begin bad++; $display("FAIL done_prio got st=%0d lv=%0d sc=%0d exp st=3 lv=1 sc=1", state_dbg, lives, score); end
    tick();
    total++; if ({score, level} !== {8'd5, 4'd2}) begin bad++; $display("FAIL done_prio_bonus got sc=%0d lvl=%0d exp sc=5 lvl=2", score, level); end
    wait_sr(n);
    total++; if ({n[7:0], rif.retry} !== {8'd4, 1'b0}) begin bad++; $display("FAIL done_prio_arm got n=%0d rt=%b exp n=4 rt=0", n, rif.retry); end
  endtask

  task automatic test_saturate_win();
    int n;
    reset = 1'b1; tick(); reset = 1'b0;
    start_btn = 1'b1; tick(); start_btn = 1'b0; tick();
    rif.key_any = 1'b1; rif.key_correct = 1'b1; tick(243);
    rif.key_any = 1'b0; rif.key_correct = 1'b0;
    rif.level_done = 1'b1; tick(); rif.level_done = 1'b0; tick();
    total++; if ({score, level} !== {8'd247, 4'd2}) begin bad++; $display("FAIL sat_l1 got sc=%0d lvl=%0d exp sc=247 lvl=2", score, level); end
    wait_sr(n); tick();
    rif.key_any = 1'b1; rif.key_correct = 1'b1; tick(3);
    rif.key_any = 1'b0; rif.key_correct = 1'b0;
    total++; if (score !== 8'd250) begin bad++; $display("FAIL sat_pre got=%0d exp=250", score); end
    rif.level_done = 1'b1; tick(); rif.level_done = 1'b0; tick();
    total++; if ({score, state_dbg, game_won, game_over} !== {8'd255, 3'd7, 1'b1, 1'b0}) begin bad++; $display("FAIL win got sc=%0d st=%0d gw=%b go=%b exp sc=255 st=7 gw=1 go=0", score, state_dbg, game_won, game_over); end
`ifdef TYPER_HISCORE_EN
    total++; if (hiscore !== 8'd255) begin bad++; $display("FAIL hiscore_win got=%0d exp=255", hiscore); end
`endif
    start_btn = 1'b1; tick(); start_btn = 1'b0;
    total++; if ({score, level, lives, rif.start_read, game_won} !== {8'd0, 4'd1, 3'd2, 1'b1, 1'b0}) begin bad++; $display("FAIL restart_win got sc=%0d lvl=%0d lv=%0d sr=%b gw=%b", score, level, lives, rif.start_read, game_won); end
`ifdef TYPER_HISCORE_EN
    total++; if (hiscore !== 8'd255) begin bad++; $display("FAIL hiscore_keep got=%0d exp=255", hiscore); end
`endif
    tick();
    rif.key_any = 1'b1; rif.key_correct = 1'b1; tick(258);
    rif.key_any = 1'b0; rif.key_correct = 1'b0;
    total++; if (score !== 8'd255) begin bad++; $display("FAIL sat_inc got=%0d exp=255", score); end
  endtask

  task automatic test_reset_in_gap();
    logic seen;
    rif.level_done = 1'b1; tick(); rif.level_done = 1'b0; tick();
    total++; if ({state_dbg, score} !== {3'd5, 8'd255}) begin bad++; $display("FAIL pre_gap got st=%0d sc=%0d exp st=5 sc=255", state_dbg, score); end
    reset = 1'b1; tick(); reset = 1'b0;
    total++; if ({state_dbg, level, score, lives, err_cnt} !== {3'd0, 4'd1, 8'd0, 3'd2, 3'd0}) begin bad++; $display("FAIL gap_reset got st=%0d lvl=%0d sc=%0d lv=%0d err=%0d", state_dbg, level, score, lives, err_cnt); end
`ifdef TYPER_HISCORE_EN
    total++; if (hiscore !== 8'd0) begin bad++; $display("FAIL hiscore_reset got=%0d exp=0", hiscore); end
`endif
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rif.start_read !== 1'b0 || state_dbg !== 3'd0) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL gap_reset_idle got start_read/state activity=%b exp=0", seen); end
  endtask

  initial begin
    reset = 1'b1; start_btn = 1'b0;
    rif.key_any = 1'b0; rif.key_correct = 1'b0;
    rif.level_done = 1'b0; rif.level_timeout = 1'b0;
    test_reset();
    test_start();
    test_level_clear();
    test_timeout_over();
    test_errors();
    test_done_wins();
    test_saturate_win();
    test_reset_in_gap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
